// File: rtl/death_timer_ctrl_if.sv
// Strobe bundle between the game FSM (master) and death_timer_ctrl (slave).
// All signals are single-cycle strobes or levels; there is no backpressure.
interface death_timer_ctrl_if #(
    parameter int LW = 2
);
    logic          TICK;
    logic          DEAD;
    logic          RELOAD;
    logic          GRESET;
    logic          LOADLIFE;
    logic          TC;
    logic          LIFE;
    logic          FLASH;
    logic [LW-1:0] LIVES;
    logic [1:0]    STATE_DBG;

    modport master (
        output TICK, DEAD, RELOAD, GRESET, LOADLIFE,
        input  TC, LIFE, LIVES, FLASH, STATE_DBG
    );

    modport slave (
        input  TICK, DEAD, RELOAD, GRESET, LOADLIFE,
        output TC, LIFE, LIVES, FLASH, STATE_DBG
    );
endinterface

// File: rtl/death_timer_ctrl.sv
// Death-pause timer and life counter for the game FSM.
// Counts TICK strobes while DEAD is high, fires a one-cycle TC, and tracks lives.
module death_timer_ctrl #(
    parameter int LIVES_INIT  = 3,
    parameter int LW          = 2,
    parameter int DELAY_TICKS = 8,
    parameter int CW          = 4
) (
    input  logic               CLK,
    input  logic               RST,
    death_timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIRE = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    localparam logic [CW-1:0] LAST_CNT   = CW'(DELAY_TICKS - 1);
    localparam logic [LW-1:0] LIVES_LOAD = LW'(LIVES_INIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          flash_q, flash_d;
    logic [LW-1:0] lives_q, lives_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flash_q <= 1'b0;
            lives_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            lives_q <= lives_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                flash_d = 1'b0;
                if (bus.DEAD) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Dropping DEAD aborts the pause even if a TICK lands on the same edge.
                if (!bus.DEAD) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    flash_d = 1'b0;
                end else if (bus.TICK) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIRE;
                        cnt_d   = '0;
                        flash_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        flash_d = ~flash_q;
                    end
                end
            end
            S_FIRE: begin
                flash_d = 1'b0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                flash_d = 1'b0;
                if (!bus.DEAD) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                flash_d = 1'b0;
            end
        endcase
        if (bus.GRESET) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            flash_d = 1'b0;
        end
    end

    always_comb begin
        lives_d = lives_q;
        if (bus.GRESET) begin
            lives_d = '0;
        end else if (bus.LOADLIFE) begin
            lives_d = LIVES_LOAD;
        end else if (bus.RELOAD && (lives_q != '0)) begin
            lives_d = lives_q - LW'(1);
        end
    end

    assign bus.TC        = (state_q == S_FIRE);
    assign bus.FLASH     = flash_q;
    assign bus.LIVES     = lives_q;
    assign bus.LIFE      = (lives_q <= LW'(1));
    assign bus.STATE_DBG = state_q;
endmodule

// File: doc/death_timer_ctrl.md
# death_timer_ctrl

Sequencer for the game's death delay and life count. It times the respawn/game-over pause that the game FSM waits on, and it tracks lives remaining. It supplies `TC` and `LIFE` to the game state machine and consumes its `DEAD`, `RELOAD`, `RESET` and `LOADLIFE` strobes. It sits between the game FSM and the free-running quarter-second tick generator.

## Interface
- `LIVES_INIT`, 3: lives loaded on `LOADLIFE`; range 1..2^LW−1.
- `LW`, 2: width of the life counter.
- `DELAY_TICKS`, 8: number of `TICK` strobes in the death pause; range 1..2^CW.
- `CW`, 4: width of the tick counter.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: synchronous, active-high block reset.
- `TICK` in 1: one-cycle timebase strobe (quarter second).
- `DEAD` in 1: level from the game FSM, high while in the died or game-over states.
- `RELOAD` in 1: one-cycle strobe, life lost; respawn.
- `GRESET` in 1: one-cycle strobe, game over; restart.
- `LOADLIFE` in 1: one-cycle strobe, load the initial lives.
- `TC` out 1: one-cycle pulse, death pause expired.
- `LIFE` out 1: high when the current life is the last one (lives ≤ 1).
- `LIVES` out LW: lives remaining.
- `FLASH` out 1: blink enable for the player sprite during the pause.

## Operation
- Timer FSM has four states: IDLE, WAIT, FIRE, HOLD.
  - IDLE: `cnt`=0. If `DEAD`=1, go to WAIT. A `TICK` sampled in IDLE is ignored.
  - WAIT: on each sampled `TICK`, `cnt`++.
    - `TICK` with `cnt`==DELAY_TICKS−1: go to FIRE and set `cnt`=0.
    - `DEAD`=0 sampled: abort to IDLE and set `cnt`=0. Abort has priority over `TICK`.
  - FIRE: go to HOLD unconditionally. `TC`=1 only in this state.
  - HOLD: wait for `DEAD`=0, then go to IDLE. `DEAD` held high never retriggers the timer.
- `FLASH` toggles on every sampled `TICK` while in WAIT. It is forced to 0 in all other states and on entry to WAIT.
- Life counter `lives` (LW bits), with updates in priority order:
  1. `GRESET` → `lives`=0.
  2. `LOADLIFE` → `lives`=LIVES_INIT.
  3. `RELOAD` → `lives`−1, saturating at 0.
- `GRESET` also forces the FSM to IDLE, `cnt`=0 and `FLASH`=0 on the same edge.
- `LIVES`=`lives`. `LIFE`=(`lives`≤1), decoded combinationally from the register.
- All outputs are driven from registered state only; there is no combinational path from any input to any output.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `lives`=0, `FLASH`=0. Therefore `TC`=0, `LIVES`=0 and `LIFE`=1 out of reset.
- `RST` dominates every other input, including in mid-pause and when it coincides with `TICK`, `GRESET` or `LOADLIFE`.
- IDLE→WAIT happens on the first edge that samples `DEAD`=1.
- `TC` goes high in the cycle after the edge that samples the DELAY_TICKS-th `TICK` after entering WAIT. It stays high for exactly one cycle.
- With `TICK` tied high and `DEAD` rising before edge 1: WAIT from edge 1, FIRE from edge 1+DELAY_TICKS, `TC` high for that one cycle, HOLD after.
- The game FSM asserts `RELOAD` or `GRESET` in the same cycle as `TC`. The `lives` update is visible one edge later.
- `LOADLIFE` together with `RELOAD`: the load wins. `GRESET` together with `LOADLIFE`: `lives`=0.
- DELAY_TICKS=1 is legal: the first `TICK` in WAIT goes to FIRE.

## Test plan
- **Reset:** assert `RST` for 2 cycles with `DEAD`=1 and `TICK`=1 → `TC`=0, `LIVES`=0, `LIFE`=1, `FLASH`=0. WAIT is entered only on the edge after `RST` drops.
- **Nominal pause:** DELAY_TICKS=8, one `TICK` every 4 cycles, `DEAD` raised → exactly one `TC` pulse, 1 cycle wide, on the cycle after the 8th `TICK`. `FLASH` toggles 7 times, then is 0 in FIRE.
- **Lives:** pulse `LOADLIFE` → `LIVES`=3, `LIFE`=0. Then 3× (`DEAD` / `TC` / `RELOAD` in the `TC` cycle / `DEAD` low) → `LIVES` reads 2, 1, 0 and `LIFE` rises after the second `RELOAD`. A 4th `RELOAD` leaves `LIVES`=0.
- **Abort:** drop `DEAD` after 3 ticks → FSM returns to IDLE with no `TC`. Re-raising `DEAD` restarts the count from 0, and `TC` comes only after 8 new ticks.
- **Hold:** keep `DEAD` high for 20 ticks after `TC` → no second `TC`. Drop and re-raise `DEAD` → a new pause starts.
- **Collisions:** `GRESET` in mid-WAIT with `TICK`=1 → next cycle shows IDLE, `LIVES`=0, `FLASH`=0. `LOADLIFE` with `RELOAD` → `LIVES`=3.
